mmc1_bank_ctrl: RTL

Register and bank-mapping core for iNES mapper 1 (MMC1) cartridges. It is the parametrised successor to the fixed-map NROM cart configuration. The block decodes CPU serial writes to $8000-$FFFF into the four MMC1 registers. From those registers it produces banked PRG ROM and CHR byte addresses, nametable mirroring (CIRAM A10) and the PRG RAM enable. It sits between the NES bus interface and the PRG/CHR BRAM ports; byte-lane selection and read-data muxing stay in the cart wrapper.

---
 rtl/mmc1_bank_ctrl_if.sv | 28 ++
 rtl/mmc1_bank_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mmc1_bank_ctrl_if.sv
// CPU/PPU bus bundle between the cart wrapper and the MMC1 bank controller.
// The master drives bus cycles and receives the banked addresses.
`timescale 1ns/1ps
interface mmc1_bank_ctrl_if #(
  parameter int PRG_ADDR_W = 18,
  parameter int CHR_ADDR_W = 17
);
  logic [14:0]           cpu_addr;
  logic [7:0]            cpu_data_i;
  logic                  cpu_rw;
  logic                  romsel;
  logic [13:0]           ppu_addr;
  logic [PRG_ADDR_W-1:0] prg_addr;
  logic [CHR_ADDR_W-1:0] chr_addr;
  logic                  ciram_a10;
  logic                  prgram_en;
  logic [4:0]            ctrl_q;

  modport master (
    output cpu_addr, cpu_data_i, cpu_rw, romsel, ppu_addr,
    input  prg_addr, chr_addr, ciram_a10, prgram_en, ctrl_q
  );

  modport slave (
    input  cpu_addr, cpu_data_i, cpu_rw, romsel, ppu_addr,
    output prg_addr, chr_addr, ciram_a10, prgram_en, ctrl_q
  );
endinterface

// File: rtl/mmc1_bank_ctrl.sv
// MMC1 serial register port and PRG/CHR bank mapping.
// Registers load through a 5-bit serial shifter; mapping outputs are combinational.
`timescale 1ns/1ps
module mmc1_bank_ctrl #(
  parameter int PRG_ADDR_W = 18,
  parameter int CHR_ADDR_W = 17,
  parameter int HAS_PRGRAM = 1
) (
  input  logic                clk_cpu,
  input  logic                rst,
  mmc1_bank_ctrl_if.slave     bus
);

  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;
  localparam logic [4:0] CTRL_RST    = 5'h0C;

  logic [4:0] shift_q, shift_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;
  logic       wr_prev_q, wr_prev_d;

  logic       wr_now;
  logic       accept;
  logic [4:0] load_val;

  assign wr_now   = bus.romsel & ~bus.cpu_rw;
  assign accept   = wr_now & ~wr_prev_q;
  assign load_val = {bus.cpu_data_i[0], shift_q[4:1]};

  always_comb begin
    shift_d   = shift_q;
    ctrl_d    = ctrl_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    wr_prev_d = wr_now;
    if (accept) begin
      if (bus.cpu_data_i[7]) begin
        shift_d = SHIFT_EMPTY;
        ctrl_d  = ctrl_q | CTRL_RST;
      end else if (!shift_q[0]) begin
        shift_d = load_val;
      end else begin
        // The marker bit reached bit 0: this is the fifth write.
        shift_d = SHIFT_EMPTY;
        unique case (bus.cpu_addr[14:13])
          2'd0:    ctrl_d = load_val;
          2'd1:    chr0_d = load_val;
          2'd2:    chr1_d = load_val;
          default: prg_d  = load_val;
        endcase
      end
    end
  end

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      shift_q   <= SHIFT_EMPTY;
      ctrl_q    <= CTRL_RST;
      chr0_q    <= 5'd0;
      chr1_q    <= 5'd0;
      prg_q     <= 5'd0;
      wr_prev_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      ctrl_q    <= ctrl_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
      wr_prev_q <= wr_prev_d;
    end
  end

  logic [3:0]  pbank;
  logic [4:0]  cbank;
  logic        a10;
  logic [17:0] prg_full;
  logic [16:0] chr_full;

  always_comb begin
    pbank = 4'd0;
    unique case (ctrl_q[3:2])
      2'd2:    pbank = bus.cpu_addr[14] ? prg_q[3:0] : 4'd0;
      2'd3:    pbank = bus.cpu_addr[14] ? 4'hF : prg_q[3:0];
      default: pbank = {prg_q[3:1], bus.cpu_addr[14]};
    endcase
  end

  always_comb begin
    cbank = {chr0_q[4:1], bus.ppu_addr[12]};
    if (ctrl_q[4]) begin
      cbank = bus.ppu_addr[12] ? chr1_q : chr0_q;
    end
  end

  always_comb begin
    a10 = 1'b0;
    unique case (ctrl_q[1:0])
      2'd0:    a10 = 1'b0;
      2'd1:    a10 = 1'b1;
      2'd2:    a10 = bus.ppu_addr[10];
      default: a10 = bus.ppu_addr[11];
    endcase
  end

  // Full-width addresses; smaller ROMs simply drop the upper bank bits.
  assign prg_full = {pbank, bus.cpu_addr[13:0]};
  assign chr_full = {cbank, bus.ppu_addr[11:0]};

  assign bus.prg_addr  = prg_full[PRG_ADDR_W-1:0];
  assign bus.chr_addr  = chr_full[CHR_ADDR_W-1:0];
  assign bus.ciram_a10 = a10;
  assign bus.prgram_en = (HAS_PRGRAM != 0) & ~prg_q[4];
  assign bus.ctrl_q    = ctrl_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.cpu_data_i[6:1], bus.ppu_addr[13]};

  if (PRG_ADDR_W < 18) begin : g_prg_trunc
    logic unused_prg_hi;
    assign unused_prg_hi = ^prg_full[17:PRG_ADDR_W];
  end

  if (CHR_ADDR_W < 17) begin : g_chr_trunc
    logic unused_chr_hi;
    assign unused_chr_hi = ^chr_full[16:CHR_ADDR_W];
  end

endmodule
